// File: rtl/bp_fe_fetch_sequencer_if.sv
// Fetch sequencer bus: backend redirect, I$ IF1/IF2 handshake, realigner
// strobe/consume and fetch-queue enqueue, plus the debug state view.
interface bp_fe_fetch_sequencer_if #(
    parameter int vaddr_width_p = 39
);
    logic                     redirect_v_i;
    logic [vaddr_width_p-1:0] redirect_pc_i;
    logic                     redirect_resume_i;
    logic                     icache_ready_i;
    logic                     icache_v_o;
    logic [vaddr_width_p-1:0] icache_vaddr_o;
    logic                     icache_hit_i;
    logic                     icache_miss_i;
    logic                     if2_v_o;
    logic [vaddr_width_p-1:0] if2_pc_o;
    logic                     fetch_instr_v_i;
    logic                     fetch_instr_yumi_o;
    logic                     queue_v_o;
    logic                     queue_ready_i;
    logic [1:0]               state_o;

    // Sequencer side
    modport master (
        input  redirect_v_i, redirect_pc_i, redirect_resume_i,
        input  icache_ready_i, icache_hit_i, icache_miss_i,
        input  fetch_instr_v_i, queue_ready_i,
        output icache_v_o, icache_vaddr_o, if2_v_o, if2_pc_o,
        output fetch_instr_yumi_o, queue_v_o, state_o
    );

    // Environment side (backend, I$, realigner, fetch queue)
    modport slave (
        output redirect_v_i, redirect_pc_i, redirect_resume_i,
        output icache_ready_i, icache_hit_i, icache_miss_i,
        output fetch_instr_v_i, queue_ready_i,
        input  icache_v_o, icache_vaddr_o, if2_v_o, if2_pc_o,
        input  fetch_instr_yumi_o, queue_v_o, state_o
    );
endinterface

// File: rtl/bp_fe_fetch_sequencer.sv
// Front-end fetch sequencer: owns the fetch PC and IF1/IF2 valid bits,
// sequences redirects, I$ miss replay and fetch-queue backpressure replay,
// and drives the realigner consume so each instruction is enqueued once.
module bp_fe_fetch_sequencer #(
    parameter int                     vaddr_width_p = 39,
    parameter logic [vaddr_width_p-1:0] reset_pc_p  = 39'h00_8000_0000
) (
    input logic                  clk_i,
    input logic                  reset_n_i,
    bp_fe_fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        e_run   = 2'd0,
        e_miss  = 2'd1,
        e_stall = 2'd2
    } state_e;

    localparam logic [vaddr_width_p-1:0] fetch_step_lp = {{(vaddr_width_p-3){1'b0}}, 3'd4};
    localparam logic [vaddr_width_p-1:0] zero_pc_lp    = {vaddr_width_p{1'b0}};

    state_e                   state_r;
    state_e                   state_next_s;
    logic [vaddr_width_p-1:0] pc_if1_r;
    logic [vaddr_width_p-1:0] pc_if2_r;
    logic [vaddr_width_p-1:0] replay_pc_r;
    logic                     v_if2_r;

    logic [vaddr_width_p-1:0] vaddr_s;
    logic                     miss_ev_s;
    logic                     stall_ev_s;
    logic                     kill_s;
    logic                     issue_s;
    logic                     if2_v_s;
    logic                     yumi_s;
    logic                     replay_go_s;

    // Event detection, issue/consume qualification and next-state selection
    always_comb begin
        vaddr_s      = {pc_if1_r[vaddr_width_p-1:2], 2'b00};
        miss_ev_s    = 1'b0;
        stall_ev_s   = 1'b0;
        state_next_s = state_r;
        // Stall uses the un-killed IF2 view to avoid a loop through kill
        if ((state_r == e_run) && !bus.redirect_v_i) begin
            miss_ev_s  = v_if2_r & bus.icache_miss_i;
            stall_ev_s = v_if2_r & bus.icache_hit_i & bus.fetch_instr_v_i & ~bus.queue_ready_i;
        end else begin
            miss_ev_s  = 1'b0;
            stall_ev_s = 1'b0;
        end
        kill_s      = bus.redirect_v_i | miss_ev_s | stall_ev_s;
        // Reset gating keeps IF1 quiet while reset is still asserted
        issue_s     = (state_r == e_run) & bus.icache_ready_i & ~kill_s & reset_n_i;
        if2_v_s     = v_if2_r & bus.icache_hit_i & ~kill_s;
        yumi_s      = if2_v_s & bus.fetch_instr_v_i & bus.queue_ready_i;
        replay_go_s = ((state_r == e_miss) & bus.icache_ready_i)
                    | ((state_r == e_stall) & bus.queue_ready_i);
        if (bus.redirect_v_i) begin
            state_next_s = e_run;
        end else begin
            case (state_r)
                e_run: begin
                    if (miss_ev_s) begin
                        state_next_s = e_miss;
                    end else if (stall_ev_s) begin
                        state_next_s = e_stall;
                    end else begin
                        state_next_s = e_run;
                    end
                end
                e_miss:  state_next_s = bus.icache_ready_i ? e_run : e_miss;
                e_stall: state_next_s = bus.queue_ready_i  ? e_run : e_stall;
                default: state_next_s = e_run;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_run;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fetch PC, IF2 tracking and replay capture
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_if1_r    <= reset_pc_p;
            pc_if2_r    <= zero_pc_lp;
            replay_pc_r <= zero_pc_lp;
            v_if2_r     <= 1'b0;
        end else if (bus.redirect_v_i) begin
            // IF2 is poisoned; the unaligned target is kept for the realigner
            pc_if1_r <= bus.redirect_pc_i;
            v_if2_r  <= 1'b0;
        end else if (miss_ev_s || stall_ev_s) begin
            // Drop the in-flight request and remember where to restart
            replay_pc_r <= pc_if2_r;
            v_if2_r     <= 1'b0;
        end else if (issue_s) begin
            pc_if1_r <= vaddr_s + fetch_step_lp;
            pc_if2_r <= pc_if1_r;
            v_if2_r  <= 1'b1;
        end else begin
            v_if2_r <= 1'b0;
            if (replay_go_s) begin
                pc_if1_r <= replay_pc_r;
            end else begin
                pc_if1_r <= pc_if1_r;
            end
        end
    end

    assign bus.icache_v_o         = issue_s;
    assign bus.icache_vaddr_o     = vaddr_s;
    assign bus.if2_v_o            = if2_v_s;
    assign bus.if2_pc_o           = pc_if2_r;
    assign bus.fetch_instr_yumi_o = yumi_s;
    assign bus.queue_v_o          = yumi_s;
    assign bus.state_o            = state_r;

endmodule

// File: tb/tb_bp_fe_fetch_sequencer.sv
// Directed bench for bp_fe_fetch_sequencer: streaming, miss replay, queue
// stall replay, redirects (plain, with miss, wrap) and reset during stall.
module tb_bp_fe_fetch_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    int   tests  = 0;
    int   failed = 0;
    int   enq_cnt;

    localparam logic [38:0] BASE = 39'h00_8000_0000;

    bp_fe_fetch_sequencer_if #(.vaddr_width_p(39)) bus ();

    bp_fe_fetch_sequencer #(.vaddr_width_p(39), .reset_pc_p(39'h00_8000_0000)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        bus.redirect_v_i      = 1'b0;
        bus.redirect_pc_i     = 39'h0;
        bus.redirect_resume_i = 1'b0;
        bus.icache_ready_i    = 1'b1;
        bus.icache_hit_i      = 1'b1;
        bus.icache_miss_i     = 1'b0;
        bus.fetch_instr_v_i   = 1'b1;
        bus.queue_ready_i     = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        defaults();
        @(posedge clk); #1;
        tests++; if (bus.state_o !== 2'd0) begin failed++; $display("FAIL rst_state got %0d exp 0", bus.state_o); end
        tests++; if (bus.icache_v_o !== 1'b0) begin failed++; $display("FAIL rst_icache_v got %b exp 0", bus.icache_v_o); end
        tests++; if (bus.queue_v_o !== 1'b0) begin failed++; $display("FAIL rst_queue_v got %b exp 0", bus.queue_v_o); end
        tests++; if (bus.if2_v_o !== 1'b0) begin failed++; $display("FAIL rst_if2_v got %b exp 0", bus.if2_v_o); end
        reset_n = 1'b1;
        #1;
        tests++; if (bus.icache_v_o !== 1'b1) begin failed++; $display("FAIL first_issue_v got %b exp 1", bus.icache_v_o); end
        tests++; if (bus.icache_vaddr_o !== BASE) begin failed++; $display("FAIL first_vaddr got %h exp %h", bus.icache_vaddr_o, BASE); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); #1;
            tests++; if (bus.icache_vaddr_o !== BASE + 39'(4*i)) begin failed++; $display("FAIL stream_vaddr%0d got %h exp %h", i, bus.icache_vaddr_o, BASE + 39'(4*i)); end
            tests++; if (bus.if2_pc_o !== BASE + 39'(4*(i-1))) begin failed++; $display("FAIL stream_if2pc%0d got %h exp %h", i, bus.if2_pc_o, BASE + 39'(4*(i-1))); end
            tests++; if (bus.queue_v_o !== 1'b1) begin failed++; $display("FAIL stream_queue_v%0d got %b exp 1", i, bus.queue_v_o); end
        end
    endtask

    task automatic test_miss();
        next_cycle(); bus.icache_hit_i = 1'b0; bus.icache_miss_i = 1'b1; #1;
        tests++; if (bus.if2_pc_o !== BASE + 39'h10) begin failed++; $display("FAIL miss_if2pc got %h exp %h", bus.if2_pc_o, BASE + 39'h10); end
        tests++; if (bus.icache_v_o !== 1'b0) begin failed++; $display("FAIL miss_kill got %b exp 0", bus.icache_v_o); end
        tests++; if (bus.if2_v_o !== 1'b0) begin failed++; $display("FAIL miss_if2_v got %b exp 0", bus.if2_v_o); end
        next_cycle(); bus.icache_miss_i = 1'b0; bus.icache_ready_i = 1'b0; #1;
        tests++; if (bus.state_o !== 2'd1) begin failed++; $display("FAIL miss_state got %0d exp 1", bus.state_o); end
        next_cycle(); #1;
        tests++; if (bus.icache_v_o !== 1'b0) begin failed++; $display("FAIL miss_wait_v got %b exp 0", bus.icache_v_o); end
        next_cycle(); bus.icache_ready_i = 1'b1; #1;
        tests++; if (bus.state_o !== 2'd1) begin failed++; $display("FAIL miss_ready_state got %0d exp 1", bus.state_o); end
        tests++; if (bus.icache_v_o !== 1'b0) begin failed++; $display("FAIL miss_ready_v got %b exp 0", bus.icache_v_o); end
        next_cycle(); bus.icache_hit_i = 1'b1; #1;
        tests++; if (bus.state_o !== 2'd0) begin failed++; $display("FAIL replay_state got %0d exp 0", bus.state_o); end
        tests++; if ({bus.icache_v_o, bus.icache_vaddr_o} !== {1'b1, BASE + 39'h10}) begin failed++; $display("FAIL replay_vaddr got %b/%h exp 1/%h", bus.icache_v_o, bus.icache_vaddr_o, BASE + 39'h10); end
        next_cycle(); #1;
        tests++; if ({bus.queue_v_o, bus.if2_pc_o} !== {1'b1, BASE + 39'h10}) begin failed++; $display("FAIL replay_enq got %b/%h exp 1/%h", bus.queue_v_o, bus.if2_pc_o, BASE + 39'h10); end
        for (int i = 0; i < 3; i++) next_cycle();
        #1;
        tests++; if (bus.icache_vaddr_o !== BASE + 39'h20) begin failed++; $display("FAIL pre_stall_vaddr got %h exp %h", bus.icache_vaddr_o, BASE + 39'h20); end
    endtask

    task automatic test_stall();
        enq_cnt = 0;
        next_cycle(); bus.queue_ready_i = 1'b0; #1;
        tests++; if (bus.if2_pc_o !== BASE + 39'h20) begin failed++; $display("FAIL stall_if2pc got %h exp %h", bus.if2_pc_o, BASE + 39'h20); end
        tests++; if (bus.fetch_instr_yumi_o !== 1'b0) begin failed++; $display("FAIL stall_yumi got %b exp 0", bus.fetch_instr_yumi_o); end
        tests++; if (bus.icache_v_o !== 1'b0) begin failed++; $display("FAIL stall_kill got %b exp 0", bus.icache_v_o); end
        if (bus.queue_v_o && bus.if2_pc_o == BASE + 39'h20) enq_cnt++;
        next_cycle(); #1;
        tests++; if (bus.state_o !== 2'd2) begin failed++; $display("FAIL stall_state got %0d exp 2", bus.state_o); end
        if (bus.queue_v_o && bus.if2_pc_o == BASE + 39'h20) enq_cnt++;
        next_cycle(); bus.queue_ready_i = 1'b1; #1;
        tests++; if (bus.icache_v_o !== 1'b0) begin failed++; $display("FAIL stall_ready_v got %b exp 0", bus.icache_v_o); end
        if (bus.queue_v_o && bus.if2_pc_o == BASE + 39'h20) enq_cnt++;
        next_cycle(); #1;
        tests++; if ({bus.state_o, bus.icache_vaddr_o} !== {2'd0, BASE + 39'h20}) begin failed++; $display("FAIL stall_replay got %0d/%h exp 0/%h", bus.state_o, bus.icache_vaddr_o, BASE + 39'h20); end
        if (bus.queue_v_o && bus.if2_pc_o == BASE + 39'h20) enq_cnt++;
        next_cycle(); #1;
        if (bus.queue_v_o && bus.if2_pc_o == BASE + 39'h20) enq_cnt++;
        tests++; if (enq_cnt !== 1) begin failed++; $display("FAIL stall_enq_once got %0d exp 1", enq_cnt); end
    endtask

    task automatic test_redirect();
        next_cycle(); bus.redirect_v_i = 1'b1; bus.redirect_pc_i = BASE + 39'h102; #1;
        tests++; if ({bus.if2_v_o, bus.queue_v_o, bus.icache_v_o} !== 3'b000) begin failed++; $display("FAIL redir_cycle got %b exp 000", {bus.if2_v_o, bus.queue_v_o, bus.icache_v_o}); end
        next_cycle(); bus.redirect_v_i = 1'b0; bus.fetch_instr_v_i = 1'b0; #1;
        tests++; if ({bus.icache_v_o, bus.icache_vaddr_o} !== {1'b1, BASE + 39'h100}) begin failed++; $display("FAIL redir_issue got %b/%h exp 1/%h", bus.icache_v_o, bus.icache_vaddr_o, BASE + 39'h100); end
        tests++; if (bus.if2_v_o !== 1'b0) begin failed++; $display("FAIL redir_poison got %b exp 0", bus.if2_v_o); end
        next_cycle(); #1;
        tests++; if ({bus.if2_v_o, bus.if2_pc_o} !== {1'b1, BASE + 39'h102}) begin failed++; $display("FAIL redir_if2pc got %b/%h exp 1/%h", bus.if2_v_o, bus.if2_pc_o, BASE + 39'h102); end
        tests++; if ({bus.icache_v_o, bus.icache_vaddr_o} !== {1'b1, BASE + 39'h104}) begin failed++; $display("FAIL redir_next got %b/%h exp 1/%h", bus.icache_v_o, bus.icache_vaddr_o, BASE + 39'h104); end
        tests++; if (bus.queue_v_o !== 1'b0) begin failed++; $display("FAIL partial_no_enq got %b exp 0", bus.queue_v_o); end
        next_cycle(); bus.fetch_instr_v_i = 1'b1; #1;
        tests++; if ({bus.state_o, bus.if2_pc_o} !== {2'd0, BASE + 39'h104}) begin failed++; $display("FAIL partial_no_stall got %0d/%h exp 0/%h", bus.state_o, bus.if2_pc_o, BASE + 39'h104); end
    endtask

    task automatic test_redirect_miss();
        next_cycle(); bus.icache_hit_i = 1'b0; bus.icache_miss_i = 1'b1; bus.redirect_v_i = 1'b1; bus.redirect_pc_i = BASE + 39'h200; #1;
        tests++; if (bus.icache_v_o !== 1'b0) begin failed++; $display("FAIL rm_kill got %b exp 0", bus.icache_v_o); end
        next_cycle(); bus.redirect_v_i = 1'b0; bus.icache_miss_i = 1'b0; bus.icache_hit_i = 1'b1; #1;
        tests++; if ({bus.state_o, bus.icache_v_o, bus.icache_vaddr_o} !== {2'd0, 1'b1, BASE + 39'h200}) begin failed++; $display("FAIL rm_issue got %0d/%b/%h exp 0/1/%h", bus.state_o, bus.icache_v_o, bus.icache_vaddr_o, BASE + 39'h200); end
        next_cycle(); #1;
        tests++; if ({bus.state_o, bus.if2_pc_o, bus.icache_vaddr_o} !== {2'd0, BASE + 39'h200, BASE + 39'h204}) begin failed++; $display("FAIL rm_follow got %0d/%h/%h exp 0/%h/%h", bus.state_o, bus.if2_pc_o, bus.icache_vaddr_o, BASE + 39'h200, BASE + 39'h204); end
    endtask

    task automatic test_wrap();
        next_cycle(); bus.redirect_v_i = 1'b1; bus.redirect_pc_i = 39'h7F_FFFF_FFFE; #1;
        next_cycle(); bus.redirect_v_i = 1'b0; #1;
        tests++; if (bus.icache_vaddr_o !== 39'h7F_FFFF_FFFC) begin failed++; $display("FAIL wrap_align got %h exp 7ffffffffc", bus.icache_vaddr_o); end
        next_cycle(); #1;
        tests++; if ({bus.icache_vaddr_o, bus.if2_pc_o} !== {39'h0, 39'h7F_FFFF_FFFE}) begin failed++; $display("FAIL wrap_next got %h/%h exp 0/7ffffffffe", bus.icache_vaddr_o, bus.if2_pc_o); end
    endtask

    task automatic test_reset_in_stall();
        next_cycle(); bus.queue_ready_i = 1'b0; #1;
        next_cycle(); #1;
        tests++; if (bus.state_o !== 2'd2) begin failed++; $display("FAIL rs_stall got %0d exp 2", bus.state_o); end
        reset_n = 1'b0; #1;
        tests++; if ({bus.state_o, bus.icache_v_o, bus.if2_v_o, bus.queue_v_o} !== 5'b00000) begin failed++; $display("FAIL rs_async got %b exp 00000", {bus.state_o, bus.icache_v_o, bus.if2_v_o, bus.queue_v_o}); end
        bus.queue_ready_i = 1'b1;
        next_cycle(); reset_n = 1'b1; #1;
        tests++; if ({bus.icache_v_o, bus.icache_vaddr_o} !== {1'b1, BASE}) begin failed++; $display("FAIL rs_resume got %b/%h exp 1/%h", bus.icache_v_o, bus.icache_vaddr_o, BASE); end
        next_cycle(); #1;
        tests++; if (bus.icache_vaddr_o !== BASE + 39'h4) begin failed++; $display("FAIL rs_next got %h exp %h", bus.icache_vaddr_o, BASE + 39'h4); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_miss();
        test_stall();
        test_redirect();
        test_redirect_miss();
        test_wrap();
        test_reset_in_stall();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bp_fe_fetch_sequencer.md
# bp_fe_fetch_sequencer

Fetch-pipeline controller for the BlackParrot front end, between next-PC selection, the I$ (IF1 issue / IF2 response) and the half-word realigner. It owns the fetch PC and the IF1/IF2 valid bits. It sequences redirects, including resume-with-partial, I$ miss replay and fetch-queue backpressure replay. It drives the realigner's IF2 strobe and consume (yumi) handshake so that every 32-bit instruction enters the fetch queue exactly once.

## Interface
Parameters:
- vaddr_width_p, 39, virtual address width
- reset_pc_p, 39'h00_8000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous assert, active-low
- redirect_v_i  in  1  backend redirect, single-cycle pulse
- redirect_pc_i  in  vaddr_width_p  redirect target
- redirect_resume_i  in  1  redirect restores a partial instruction; qualified by redirect_v_i
- icache_ready_i  in  1  I$ can accept an IF1 request
- icache_v_o  out  1  IF1 fetch request
- icache_vaddr_o  out  vaddr_width_p  IF1 fetch address, always 4-byte aligned
- icache_hit_i  in  1  IF2 data valid this cycle
- icache_miss_i  in  1  IF2 missed this cycle; mutually exclusive with icache_hit_i
- if2_v_o  out  1  to realigner: IF2 data valid and not poisoned
- if2_pc_o  out  vaddr_width_p  to realigner: IF2 PC, the original unaligned PC when first fetched after a redirect
- fetch_instr_v_i  in  1  realigner has a full instruction
- fetch_instr_yumi_o  out  1  to realigner: instruction consumed
- queue_v_o  out  1  enqueue to fetch queue
- queue_ready_i  in  1  fetch queue can accept
- state_o  out  2  current state, for debug and for the verification bench

## Operation
States: e_run=0, e_miss=1, e_stall=2.

Registers:
- pc_if1_r: PC to issue next.
- pc_if2_r and v_if2_r: the request currently in IF2.
- replay_pc_r: PC to re-issue after a miss or stall.

Issue and IF2 tracking:
- icache_v_o = (state==e_run) & icache_ready_i & ~kill.
- icache_vaddr_o = {pc_if1_r[vaddr_width_p-1:2], 2'b00}.
- On issue: pc_if1_r <= icache_vaddr_o + 4; pc_if2_r <= pc_if1_r; v_if2_r <= 1. Otherwise v_if2_r <= 0.
- if2_v_o = v_if2_r & icache_hit_i & ~kill. if2_pc_o = pc_if2_r.
- yumi: queue_v_o = fetch_instr_yumi_o = if2_v_o & fetch_instr_v_i & queue_ready_i.
- kill = redirect_v_i, or a miss/stall event this cycle.

Redirect (highest priority, any state):
- pc_if1_r <= redirect_pc_i. v_if2_r <= 0 (IF2 poisoned). Next state e_run.
- No enqueue or yumi in the redirect cycle.
- redirect_resume_i changes nothing here; the realigner handles it.

Miss (state e_run, v_if2_r & icache_miss_i, no redirect):
- replay_pc_r <= pc_if2_r. The in-flight IF1 request is dropped (v_if2_r <= 0).
- Next state e_miss.
- In e_miss: on icache_ready_i, pc_if1_r <= replay_pc_r and state <= e_run. Issue happens the following cycle.

Stall (state e_run, if2_v_o & fetch_instr_v_i & ~queue_ready_i, no redirect):
- Same replay capture as a miss. No yumi, so the realigner's partial is kept.
- Next state e_stall.
- In e_stall: on queue_ready_i, pc_if1_r <= replay_pc_r and state <= e_run.

Non-events:
- An unaligned IF2 with fetch_instr_v_i=0 is not a stall. The realigner stores the half-word and the sequencer keeps streaming.
- A replayed IF2 with the partial held re-presents the same aligned word, which the realigner re-assembles.

## Timing
- Reset values (asynchronous, while reset_n_i=0):
  - state=e_run; pc_if1_r=reset_pc_p; v_if2_r=0; replay_pc_r=0.
  - All valid/yumi outputs are 0.
  - icache_v_o is held low while reset is asserted; the first issue is the first edge after deassertion with icache_ready_i=1.
- Latency: issue at cycle N gives IF2 at N+1. Throughput is 1 fetch/cycle in steady state.
- Redirect at cycle N: new PC issued at N+1 if icache_ready_i is high.
- Miss or stall at N: no issue at N+1. The replay issues one cycle after the ready condition is observed.
- Simultaneous events: redirect beats miss and stall. A miss in the same cycle as redirect is ignored.
- Reset mid-miss or mid-stall: returns to e_run; replay_pc_r is discarded.
- PC arithmetic wraps modulo 2^vaddr_width_p.

## Test plan
- Reset with reset_pc_p=0x80000000, icache_ready_i=1, all hits, queue ready -> icache_vaddr_o 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; queue_v_o high from the second cycle.
- Redirect to 0x80000102 with an IF2 in flight -> if2_v_o=0 that cycle; next issue is 0x80000100; if2_pc_o=0x80000102; the following issue is 0x80000104.
- IF2 miss at pc 0x80000010 -> state_o=1; icache_v_o=0 until icache_ready_i returns; then 0x80000010 is re-issued and state_o=0.
- Queue stall at 0x80000020 with realigner partial held -> yumi=0, state_o=2; after queue_ready_i, 0x80000020 is re-issued; the instruction is enqueued exactly once.
- Redirect in the same cycle as a miss -> state_o stays 0; the redirect target issues next cycle; no replay.
- Assert reset_n_i low during e_stall -> outputs go to 0 immediately; after release, the fetch resumes at 0x80000000.
